fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: width of addresses and instruction words.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 The block SHALL have parameter FQ_DEPTH, default 2: fetch-queue entries and maximum outstanding requests.
REQ-004 Port clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port StallF, input, 1: from the hazard unit; holds the current F-stage outputs.
REQ-007 Port PCSrcE, input, 1: taken branch or jump redirect from Execute.
REQ-008 Port PCTargetE, input, DATA_WIDTH: redirect target address.
REQ-009 Port imem_req, output, 1: instruction-memory request valid.
REQ-010 Port imem_addr, output, DATA_WIDTH: request address.
REQ-011 Port imem_gnt, input, 1: request accepted this cycle.
REQ-012 Port imem_rvalid, input, 1: response valid; responses return in request order, at least 1 cycle after gnt.
REQ-013 Port imem_rdata, input, DATA_WIDTH: response instruction word.
REQ-014 Port pcF, output, DATA_WIDTH: address of the presented instruction, feeding the fetch/decode register.
REQ-015 Port instr, output, DATA_WIDTH: presented instruction word.
REQ-016 Port PCPlus4F, output, DATA_WIDTH: pcF + 4.
REQ-017 Port FetchValidF, output, 1: high when instr is a real fetched instruction.

Function
REQ-018 A fetch_pc register SHALL hold the next request address; imem_addr = fetch_pc.
REQ-019 imem_req SHALL be high when (outstanding + queue count) < FQ_DEPTH, PCSrcE is low and rst is low.
REQ-020 A grant (imem_req & imem_gnt) SHALL increment fetch_pc by 4 modulo 2^32 and push fetch_pc into an in-order address tag queue.
REQ-021 On imem_rvalid with discard_cnt = 0, the block SHALL pop the tag and push {tag, imem_rdata} into the fetch queue; the entry is visible at the outputs the next cycle.
REQ-022 On imem_rvalid with discard_cnt > 0, the block SHALL pop the tag, drop the data and decrement discard_cnt.
REQ-023 With the fetch queue non-empty: FetchValidF = 1, pcF/instr = head entry, PCPlus4F = pcF + 4 (modulo 2^32).
REQ-024 With the fetch queue empty: FetchValidF = 0, instr = NOP 32'h00000013, pcF = fetch_pc, PCPlus4F = fetch_pc + 4.
REQ-025 The head SHALL pop when StallF = 0 and the queue is non-empty; with StallF = 1 all outputs hold.
REQ-026 Simultaneous push and pop on a full queue SHALL be legal and keep the count unchanged; push on a full queue without pop cannot occur, per REQ-019.
REQ-027 With PCSrcE = 1 the block SHALL: set fetch_pc to {PCTargetE[31:2], 2'b00}; empty the fetch queue; set discard_cnt to the number of outstanding requests minus any response consumed that cycle; drop any response arriving that cycle; issue no request that cycle.
REQ-028 Redirect SHALL take priority over StallF, pop, push and grant.
REQ-029 The first request for the target SHALL be issued in the cycle after PCSrcE.
REQ-030 Best-case latency: request at cycle N, gnt at N, rvalid at N+1, FetchValidF at N+2.
REQ-031 The block SHALL contain no FSM; control state is the outstanding counter, discard_cnt and queue pointers, all bounded by FQ_DEPTH.

Reset
REQ-032 rst SHALL set fetch_pc = RESET_PC, clear the outstanding counter, discard_cnt and both queues, and drive imem_req = 0, FetchValidF = 0, instr = NOP, pcF = RESET_PC and PCPlus4F = RESET_PC + 4.
REQ-033 rst SHALL override all other inputs in the same cycle; mid-operation reset abandons in-flight requests, and instruction memory SHALL be reset by the same rst.
REQ-034 The first request SHALL issue in the first cycle with rst low.

Structure
REQ-035 NOP_INSTR (32'h00000013) and the RESET_PC default SHALL live in the shared package riscv_pkg.
REQ-036 Tag queue and fetch queue SHALL be instances of one sub-module, fetch_fifo, a parameterised-width synchronous FIFO with push, pop, full, empty and count.

Verification
REQ-037 Reset release, gnt tied high, 1-cycle rvalid -> addresses 0x0, 0x4, 0x8 issued; FetchValidF rises 2 cycles after the first request; pcF sequence 0x0, 0x4, 0x8.
REQ-038 StallF held high for 5 cycles with a full queue -> imem_req low, pcF/instr stable, no entry lost; release resumes in order.
REQ-039 PCSrcE with PCTargetE = 0x0000_0103 while 2 requests are outstanding -> both responses dropped; next imem_addr = 0x0000_0100; FetchValidF low until the 0x100 response returns.
REQ-040 PCSrcE with StallF = 1 and imem_rvalid = 1 in the same cycle -> redirect wins; queue empty next cycle; response dropped.
REQ-041 fetch_pc = 0xFFFF_FFFC, granted -> next imem_addr = 0x0000_0000; PCPlus4F for that entry = 0x0000_0000.
REQ-042 rst asserted mid-stream with a full queue -> next cycle FetchValidF = 0, instr = 0x00000013, imem_addr = RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline constants: canonical NOP encoding and the default
// reset fetch address.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master)
// and instruction memory (slave).
interface fetch_unit_if #(
    parameter int DATA_WIDTH = 32
) ();

    logic                  imem_req;
    logic [DATA_WIDTH-1:0] imem_addr;
    logic                  imem_gnt;
    logic                  imem_rvalid;
    logic [DATA_WIDTH-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush, used for both the in-flight address tags
// and the fetched-instruction queue.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1'b1);
        end
    endfunction

    assign full  = (count_r == CW'(DEPTH));
    assign empty = (count_r == {CW{1'b0}});
    assign count = count_r;
    assign rdata = mem_r[rd_ptr_r];

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    always_comb begin
        do_push_s = 1'b0;
        do_pop_s  = 1'b0;
        if (push && (!full || pop)) begin
            do_push_s = 1'b1;
        end else begin
            do_push_s = 1'b0;
        end
        if (pop && !empty) begin
            do_pop_s = 1'b1;
        end else begin
            do_pop_s = 1'b0;
        end
    end

    // Pointer and occupancy state; flush behaves like a local reset.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; stale words are harmless once the pointers are cleared.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Pipelined instruction fetch: keeps up to FQ_DEPTH requests in flight, queues
// returned words in order and squashes wrong-path responses after a redirect.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT),
    parameter int                    FQ_DEPTH   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  StallF,
    input  logic                  PCSrcE,
    input  logic [DATA_WIDTH-1:0] PCTargetE,
    fetch_unit_if.master          imem,
    output logic [DATA_WIDTH-1:0] pcF,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] PCPlus4F,
    output logic                  FetchValidF
);

    localparam int CW = $clog2(FQ_DEPTH + 1);
    localparam int OW = CW + 1;

    logic [DATA_WIDTH-1:0]   fetch_pc_r;
    logic [CW-1:0]           discard_cnt_r;

    logic [DATA_WIDTH-1:0]   target_s;
    logic [OW-1:0]           occ_s;
    logic                    req_s;
    logic                    gnt_s;
    logic                    rsp_s;
    logic                    tag_push_s;
    logic                    fq_push_s;
    logic                    fq_pop_s;

    logic [DATA_WIDTH-1:0]   tag_rdata_s;
    logic                    tag_full_s;
    logic                    tag_empty_s;
    logic [CW-1:0]           tag_count_s;
    logic [2*DATA_WIDTH-1:0] fq_rdata_s;
    logic                    fq_full_s;
    logic                    fq_empty_s;
    logic [CW-1:0]           fq_count_s;

    assign target_s       = PCTargetE & ~{{(DATA_WIDTH-2){1'b0}}, 2'b11};
    assign imem.imem_req  = req_s;
    assign imem.imem_addr = fetch_pc_r;

    // Tag queue occupancy doubles as the outstanding-request count.
    always_comb begin
        occ_s      = OW'(tag_count_s) + OW'(fq_count_s);
        req_s      = (occ_s < OW'(FQ_DEPTH)) && !PCSrcE && !rst;
        gnt_s      = req_s && imem.imem_gnt;
        rsp_s      = imem.imem_rvalid && !tag_empty_s;
        tag_push_s = gnt_s && !tag_full_s;
        fq_push_s  = 1'b0;
        fq_pop_s   = 1'b0;
        if (rsp_s && (discard_cnt_r == {CW{1'b0}}) && !PCSrcE && (!fq_full_s || !StallF)) begin
            fq_push_s = 1'b1;
        end else begin
            fq_push_s = 1'b0;
        end
        if (!StallF && !fq_empty_s && !PCSrcE) begin
            fq_pop_s = 1'b1;
        end else begin
            fq_pop_s = 1'b0;
        end
    end

    fetch_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FQ_DEPTH),
        .CW    (CW)
    ) u_tag_q (
        .clk   (clk),
        .rst   (rst),
        .flush (1'b0),
        .push  (tag_push_s),
        .pop   (rsp_s),
        .wdata (fetch_pc_r),
        .rdata (tag_rdata_s),
        .full  (tag_full_s),
        .empty (tag_empty_s),
        .count (tag_count_s)
    );

    fetch_fifo #(
        .WIDTH (2 * DATA_WIDTH),
        .DEPTH (FQ_DEPTH),
        .CW    (CW)
    ) u_fetch_q (
        .clk   (clk),
        .rst   (rst),
        .flush (PCSrcE),
        .push  (fq_push_s),
        .pop   (fq_pop_s),
        .wdata ({tag_rdata_s, imem.imem_rdata}),
        .rdata (fq_rdata_s),
        .full  (fq_full_s),
        .empty (fq_empty_s),
        .count (fq_count_s)
    );

    // Next-request PC and the count of wrong-path responses still to be dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_r    <= RESET_PC;
            discard_cnt_r <= {CW{1'b0}};
        end else if (PCSrcE) begin
            fetch_pc_r    <= target_s;
            discard_cnt_r <= tag_count_s - CW'(rsp_s);
        end else begin
            if (gnt_s) begin
                fetch_pc_r <= fetch_pc_r + DATA_WIDTH'(32'd4);
            end
            if (rsp_s && (discard_cnt_r != {CW{1'b0}})) begin
                discard_cnt_r <= discard_cnt_r - CW'(1'b1);
            end
        end
    end

    // An empty queue presents a NOP bubble at the current fetch PC.
    always_comb begin
        FetchValidF = 1'b0;
        pcF         = fetch_pc_r;
        instr       = DATA_WIDTH'(NOP_INSTR);
        if (!fq_empty_s) begin
            FetchValidF = 1'b1;
            pcF         = fq_rdata_s[2*DATA_WIDTH-1 -: DATA_WIDTH];
            instr       = fq_rdata_s[DATA_WIDTH-1:0];
        end else begin
            FetchValidF = 1'b0;
            pcF         = fetch_pc_r;
            instr       = DATA_WIDTH'(NOP_INSTR);
        end
    end

    assign PCPlus4F = pcF + DATA_WIDTH'(32'd4);

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit: an in-order instruction memory with random
// grant and latency, checked against a program-order model of the fetch stream.
module tb_fetch_unit;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        StallF;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] pcF;
    logic [31:0] instr;
    logic [31:0] PCPlus4F;
    logic        FetchValidF;

    fetch_unit_if #(.DATA_WIDTH(32)) imem_bus ();

    fetch_unit #(
        .DATA_WIDTH (32),
        .RESET_PC   (RPC),
        .FQ_DEPTH   (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .StallF      (StallF),
        .PCSrcE      (PCSrcE),
        .PCTargetE   (PCTargetE),
        .imem        (imem_bus),
        .pcF         (pcF),
        .instr       (instr),
        .PCPlus4F    (PCPlus4F),
        .FetchValidF (FetchValidF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } rsp_t;

    rsp_t        rq[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          fq_cnt = 0;
    int          consumed = 0;
    logic [31:0] exp_pc = RPC;
    logic [31:0] exp_req_addr = RPC;
    bit          gnt_rand = 1'b0;
    int          lat_lo = 1;
    int          lat_hi = 1;

    logic        s_req;
    logic [31:0] s_addr;
    logic        s_valid;
    logic [31:0] s_pc;
    logic [31:0] s_instr;
    logic [31:0] s_pc4;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic bit rsp_ready();
        return (rq.size() > 0) && (rq[0].due <= cyc);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, check settled outputs, advance the model across the edge.
    task automatic step(input logic st, input logic br, input logic [31:0] tgt, input logic do_rst);
        logic gnt_v;
        logic rv;
        logic exp_valid;
        rsp_t h;
        rv    = !do_rst && rsp_ready();
        gnt_v = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        rst                  = do_rst;
        StallF               = st;
        PCSrcE               = br;
        PCTargetE            = tgt;
        imem_bus.imem_gnt    = gnt_v;
        imem_bus.imem_rvalid = rv;
        imem_bus.imem_rdata  = rv ? mem_word(rq[0].addr) : $urandom;
        #1;
        s_req   = imem_bus.imem_req;
        s_addr  = imem_bus.imem_addr;
        s_valid = FetchValidF;
        s_pc    = pcF;
        s_instr = instr;
        s_pc4   = PCPlus4F;

        exp_valid = (fq_cnt != 0);
        check_val("imem_req", s_req, !do_rst && !br && ((rq.size() + fq_cnt) < DEPTH));
        check_val("valid", s_valid, exp_valid);
        if (exp_valid) begin
            check_val("pcF", s_pc, exp_pc);
            check_val("instr", s_instr, mem_word(exp_pc));
            check_val("PCPlus4F", s_pc4, exp_pc + 32'd4);
        end else begin
            check_val("bubble_pc", s_pc, exp_req_addr);
            check_val("bubble_instr", s_instr, NOP);
            check_val("bubble_pc4", s_pc4, exp_req_addr + 32'd4);
        end

        if (do_rst) begin
            rq.delete();
            fq_cnt       = 0;
            epoch++;
            exp_pc       = RPC;
            exp_req_addr = RPC;
        end else if (br) begin
            if (rv) h = rq.pop_front();
            fq_cnt       = 0;
            epoch++;
            exp_pc       = tgt & 32'hFFFF_FFFC;
            exp_req_addr = tgt & 32'hFFFF_FFFC;
        end else begin
            if (exp_valid && !st) begin
                fq_cnt--;
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            if (rv) begin
                h = rq.pop_front();
                if (h.epoch == epoch) fq_cnt++;
            end
            if (s_req && gnt_v) begin
                check_val("req_addr", s_addr, exp_req_addr);
                rq.push_back('{addr: exp_req_addr, due: cyc + int'($urandom_range(lat_lo, lat_hi)), epoch: epoch});
                exp_req_addr = exp_req_addr + 32'd4;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc_hold;
        bit          found;
        rst = 1'b1; StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
        imem_bus.imem_gnt = 1'b0; imem_bus.imem_rvalid = 1'b0; imem_bus.imem_rdata = 32'h0;
        @(posedge clk);
        @(negedge clk);

        // Reset release, gnt high, 1-cycle latency: addresses 0,4 then valid 2 cycles after first request.
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check_val("rst_valid", s_valid, 1'b0);
        check_val("rst_instr", s_instr, NOP);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check_val("first_req", s_req, 1'b1);
        check_val("first_addr", s_addr, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check_val("k1_addr", s_addr, 32'h4);
        check_val("k1_valid", s_valid, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check_val("k2_valid", s_valid, 1'b1);
        check_val("k2_pc", s_pc, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check_val("k3_pc", s_pc, 32'h4);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0);
            if (s_valid) begin
                found = 1'b1;
                check_val("k_pc8", s_pc, 32'h8);
            end
        end
        check_val("pc8_seen", found, 1'b1);

        // Stall with a full queue: requests stop, head holds, then resumes in order.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
        pc_hold = s_pc;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b0);
            check_val("stall_req", s_req, 1'b0);
            check_val("stall_pc", s_pc, pc_hold);
        end
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b0);

        // Redirect to 0x103 with two requests in flight.
        lat_lo = 3; lat_hi = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (rq.size() == 2) found = 1'b1;
            else step(1'b0, 1'b0, 32'h0, 1'b0);
        end
        check_val("two_outstanding", found, 1'b1);
        step(1'b0, 1'b1, 32'h0000_0103, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check_val("redir_addr", s_addr, 32'h0000_0100);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0);
            if (s_valid) begin
                found = 1'b1;
                check_val("redir_first_pc", s_pc, 32'h0000_0100);
            end
        end
        check_val("redir_valid_seen", found, 1'b1);

        // Redirect while stalled and a response lands: redirect wins, queue empties.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (rsp_ready()) found = 1'b1;
            else step(1'b0, 1'b0, 32'h0, 1'b0);
        end
        check_val("rsp_ready_seen", found, 1'b1);
        step(1'b1, 1'b1, 32'h0000_0040, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        check_val("redir_stall_valid", s_valid, 1'b0);

        // Address wrap at the top of the space.
        lat_lo = 1; lat_hi = 1;
        step(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0);
            if (s_valid && s_pc == 32'hFFFF_FFFC) begin
                found = 1'b1;
                check_val("wrap_pc4", s_pc4, 32'h0);
            end
        end
        check_val("wrap_seen", found, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0);
            if (s_valid && s_pc == 32'h0) found = 1'b1;
        end
        check_val("wrap_zero_seen", found, 1'b1);

        // Mid-stream reset with a full queue.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
        check_val("pre_rst_valid", s_valid, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check_val("post_rst_valid", s_valid, 1'b0);
        check_val("post_rst_instr", s_instr, NOP);
        check_val("post_rst_addr", s_addr, RPC);

        // Random traffic: grant, latency, stall, redirect and reset all randomised.
        gnt_rand = 1'b1; lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 999));
            if (r < 5)       step(1'b0, 1'b0, 32'h0, 1'b1);
            else if (r < 35) step(1'($urandom_range(0, 3) == 0), 1'b1, $urandom, 1'b0);
            else             step(1'($urandom_range(0, 3) == 0), 1'b0, 32'h0, 1'b0);
        end
        check_val("progress", consumed > 300, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
